// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: FSM states and
// address-field widths at the default geometry (16 lines x 4 words).
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;
  localparam int OFF_W     = $clog2(DEF_WORDS);
  localparam int IDX_W     = $clog2(DEF_LINES);
  localparam int TAG_W     = 32 - IDX_W - OFF_W - 2;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [OFF_W-1:0] off_t;

endpackage

// File: rtl/icache_line_store.sv
// Data, tag and valid storage for the instruction cache: one async read
// port, one write port used by refill, and a bulk valid clear.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAGW  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(LINES)-1:0] rdIdx,
  input  logic [$clog2(WORDS)-1:0] rdOff,
  output logic [31:0]              rdData,
  output logic [TAGW-1:0]          rdTag,
  output logic                     rdValid,
  input  logic                     dataWe,
  input  logic [$clog2(LINES)-1:0] wrIdx,
  input  logic [$clog2(WORDS)-1:0] wrOff,
  input  logic [31:0]              wrData,
  input  logic                     lineWe,
  input  logic                     lineValid,
  input  logic [TAGW-1:0]          lineTag,
  input  logic                     lineClr,
  input  logic [$clog2(LINES)-1:0] clrIdx,
  input  logic                     invAll
);

  logic [31:0]     dataArr [LINES][WORDS];
  logic [TAGW-1:0] tagArr  [LINES];
  logic [LINES-1:0] validBits;

  assign rdData  = dataArr[rdIdx][rdOff];
  assign rdTag   = tagArr[rdIdx];
  assign rdValid = validBits[rdIdx];

  // Data and tags are never reset; only the valid bits gate a hit.
  always_ff @(posedge clk) begin
    if (dataWe) begin
      dataArr[wrIdx][wrOff] <= wrData;
    end
    if (lineWe) begin
      tagArr[wrIdx] <= lineTag;
    end
  end

  // A bulk invalidate wins over a line completing in the same cycle, so an
  // invalidate arriving with the final refill word still leaves the line dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      validBits <= '0;
    end else if (invAll) begin
      validBits <= '0;
    end else if (lineWe) begin
      validBits[wrIdx] <= lineValid;
    end else if (lineClr) begin
      validBits[clrIdx] <= 1'b0;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
// Define ICACHE_STATS_EN to add the hit_count/miss_count ports.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_imem,
  output logic [31:0] imem_instn,
  output logic        imem_stall,
  input  logic        icache_inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFFW = $clog2(WORDS);
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 32 - IDXW - OFFW - 2;

  state_t          state;
  logic [TAGW-1:0] pcTag;
  logic [TAGW-1:0] missTag;
  logic [TAGW-1:0] rdTag;
  logic [IDXW-1:0] pcIdx;
  logic [IDXW-1:0] missIdx;
  logic [OFFW-1:0] pcOff;
  logic [OFFW-1:0] wordCnt;
  logic            rdValid;
  logic            hit;
  logic            startRefill;
  logic            memReq;
  logic            abort;
  logic            dataWe;
  logic            lastAck;
  logic            unusedPcBits;

  assign pcOff        = pc_imem[OFFW+1:2];
  assign pcIdx        = pc_imem[IDXW+OFFW+1:OFFW+2];
  assign pcTag        = pc_imem[31:IDXW+OFFW+2];
  assign unusedPcBits = ^pc_imem[1:0];

  assign hit         = rdValid && (rdTag == pcTag) && (state == IDLE);
  assign imem_stall  = ~hit;
  assign startRefill = (state == IDLE) && !hit && !icache_inv;
  assign dataWe      = memReq && mem_ack;
  assign lastAck     = dataWe && (wordCnt == OFFW'(WORDS - 1));

  assign mem_req  = memReq;
  assign mem_addr = {missTag, missIdx, wordCnt, 2'b00};

  // Refill writes go to the latched miss line; the entry clear targets the
  // line currently being fetched, which is the same line one cycle earlier.
  icache_line_store #(
    .LINES(LINES),
    .WORDS(WORDS),
    .TAGW (TAGW)
  ) lineStore (
    .clk      (clk),
    .reset    (reset),
    .rdIdx    (pcIdx),
    .rdOff    (pcOff),
    .rdData   (imem_instn),
    .rdTag    (rdTag),
    .rdValid  (rdValid),
    .dataWe   (dataWe),
    .wrIdx    (missIdx),
    .wrOff    (wordCnt),
    .wrData   (mem_rdata),
    .lineWe   (lastAck),
    .lineValid(~abort),
    .lineTag  (missTag),
    .lineClr  (startRefill),
    .clrIdx   (pcIdx),
    .invAll   (icache_inv)
  );

  // An invalidate during refill cannot cancel the bus transfer, so it is
  // remembered in abort and the finished line is simply left invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      memReq  <= 1'b0;
      wordCnt <= '0;
      missTag <= '0;
      missIdx <= '0;
      abort   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startRefill) begin
            missTag <= pcTag;
            missIdx <= pcIdx;
            wordCnt <= '0;
            abort   <= 1'b0;
            memReq  <= 1'b1;
            state   <= REFILL;
          end
        end
        REFILL: begin
          if (icache_inv) begin
            abort <= 1'b1;
          end
          if (mem_ack) begin
            wordCnt <= wordCnt + 1'b1;
            if (lastAck) begin
              memReq <= 1'b0;
              state  <= IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (startRefill) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the pipeline's fetch port and a slower backing instruction memory. On a hit it returns the instruction combinationally in the same cycle, so fetch timing matches a single-cycle imem. On a miss it asserts a stall toward the fetch/decode hazard logic and refills one whole line over a word-serial req/ack handshake.

## Interface
Parameters:
- `LINES`, 16, number of lines; power of two, ≥2.
- `WORDS`, 4, 32-bit words per line; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_imem` in 32: fetch byte address; bits [1:0] ignored.
- `imem_instn` out 32: instruction word; valid when `imem_stall`=0.
- `imem_stall` out 1: hold F/D; OR into `stallF`/`stallD`.
- `icache_inv` in 1: one-cycle pulse; invalidate all lines.
- `mem_req` out 1: backing-memory word request.
- `mem_addr` out 32: word-aligned request address.
- `mem_ack` in 1: request accepted, data present.
- `mem_rdata` in 32: word data, valid in the `mem_ack` cycle.
- `hit_count`, `miss_count` out 32 each: present only with `ICACHE_STATS_EN`.

## Operation
- Address split: offset = pc[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits (24 at defaults).
- `hit` = valid[index] & (tag_arr[index]==tag) & state==IDLE.
- `imem_instn` = data[index][offset] (async array read); `imem_stall` = ~hit.
- FSM with states IDLE and REFILL:
  - IDLE, miss, no `icache_inv`: latch tag/index into `miss_tag`/`miss_idx`, `word_cnt`←0, `abort`←0, go to REFILL.
  - REFILL: `mem_req`=1, `mem_addr`={miss_tag, miss_idx, word_cnt, 2'b00}. On `mem_ack`, write `mem_rdata` to data[miss_idx][word_cnt] and increment `word_cnt`. The ack with `word_cnt`==WORDS-1 writes tag_arr[miss_idx]←miss_tag, sets valid[miss_idx]←~abort, and returns to IDLE.
- Words are fetched in order 0..WORDS-1 with no critical-word-first. valid[miss_idx] is cleared on REFILL entry, so a partially written line is never a hit.
- `icache_inv` in IDLE clears all valid bits. If the same cycle misses, no refill starts that cycle.
- `icache_inv` in REFILL clears all valid bits and sets `abort`. The transfer finishes, but the line is left invalid; the re-fetch then misses and refills again.
- Data arrays are not reset; only valid bits are cleared.

## Timing
- Reset values: state IDLE; all valid 0; `mem_req` 0; `mem_addr` 0; `word_cnt` 0; counters 0. `imem_stall` is 1 after reset, since the first fetch misses.
- Hit latency: 0 cycles (combinational).
- Miss penalty with zero-wait memory (`mem_ack` in every REFILL cycle): WORDS+1 stall cycles (5 at default). The instruction is returned in the first IDLE cycle after refill.
- Each memory wait cycle adds one stall cycle.
- `mem_req`/`mem_addr` stay stable until `mem_ack`. `mem_ack` is ignored when `mem_req`=0. There is a one-word-per-ack transfer and no outstanding-request queue.
- `reset` in REFILL returns to IDLE and drops `mem_req` at that edge. The backing memory tolerates an abandoned request.
- `pc_imem` may change during REFILL; the refill uses the latched `miss_tag`/`miss_idx` only.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on every cycle with `hit`=1.
  - `miss_count` increments on every IDLE→REFILL transition.
  - Both counters are 32-bit, wrap to 0, and are cleared by `reset`.
- Not defined: the ports and counters are absent, with no other behaviour change.

## Structure
- `icache_pkg` holds:
  - the `state_t` enum {IDLE, REFILL};
  - localparam derivations (offset/index/tag widths via `$clog2`);
  - `tag_t`, `idx_t` and `off_t` typedefs.
- Sub-module `icache_line_store` holds the data, tag and valid arrays: async read port, single write port, bulk valid clear.
- FSM, counters and handshake live in `icache_dm`.

## Test plan
- Reset, fetch 0x0000_0040 with zero-wait memory → `mem_addr` 0x40,0x44,0x48,0x4C; stall 5 cycles; `imem_instn`=word at 0x40 in cycle 6; fetch 0x44 → hit, stall 0.
- Memory inserts 2 wait cycles per word on refill of 0x100 → stall 13 cycles; `mem_addr` holds each value until its ack.
- Conflict test: fetch 0x000 then 0x100 (same index, LINES=16, WORDS=4), then 0x000 → three misses, each refilling 4 words.
- `icache_inv` in the 2nd REFILL cycle of 0x200 → transfer finishes, line invalid, refetch of 0x200 misses again; in IDLE → the next fetch of a previously hit address misses.
- `reset` asserted mid-REFILL → `mem_req`=0 the next cycle, state IDLE, prior hits now miss.
- With `ICACHE_STATS_EN`: 1 miss then 3 hit cycles → `miss_count`=1, `hit_count`=3.
